// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// mips_ctrl_pkg: state, opcode, funct and ALU encodings shared by the control.
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMREAD  = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWRITE = 4'd6,
    ST_EXECUTE  = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_ADDIEXEC = 4'd10,
    ST_ADDIWB   = 4'd11,
    ST_JUMP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_slt = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// alu_decoder: maps (ALUOp, funct) to the 3-bit ALU operation.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  logic [2:0] funct_alu;

  always_comb begin
    funct_valid = 1'b1;
    funct_alu   = c_alu_add;
    case (funct)
      c_fn_add: funct_alu = c_alu_add;
      c_fn_sub: funct_alu = c_alu_sub;
      c_fn_and: funct_alu = c_alu_and;
      c_fn_or:  funct_alu = c_alu_or;
      c_fn_slt: funct_alu = c_alu_slt;
      default:  funct_valid = 1'b0;
    endcase

    case (alu_op)
      ALUOP_ADD: alu_control = c_alu_add;
      ALUOP_SUB: alu_control = c_alu_sub;
      default:   alu_control = funct_alu;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control: Moore FSM driving every datapath control of the core.
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        overflow,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        PCWriteCond,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        IRWrite,
  output logic [2:0]  ALUControl,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        exception
);

  state_t     state_q, state_d;
  logic       ovf_flag_q, ovf_flag_d;
  alu_op_t    alu_op;
  logic       alu_en;
  logic [2:0] alu_ctrl_dec;
  logic       funct_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode            = instruction[31:26];
  assign funct             = instruction[5:0];
  assign unused_instr_bits = ^instruction[25:6];
  assign state             = state_q;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_ctrl_dec),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RESET;
      ovf_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ovf_flag_d  = ovf_flag_q;
    alu_op      = ALUOP_ADD;
    alu_en      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    illegal     = 1'b0;
    exception   = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        MemRead    = 1'b1;
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        alu_en     = 1'b1;
        ovf_flag_d = 1'b0;
        state_d    = ST_DECODE;
      end
      ST_DECODE: begin
        // The adder precomputes the branch target while the opcode is decoded.
        ALUSrcB = 2'b11;
        alu_en  = 1'b1;
        case (opcode)
          c_op_lw, c_op_sw: state_d = ST_MEMADR;
          c_op_beq:         state_d = ST_BRANCH;
          c_op_addi:        state_d = ST_ADDIEXEC;
          c_op_j:           state_d = ST_JUMP;
          c_op_rtype: begin
            illegal = ~funct_valid;
            state_d = funct_valid ? ST_EXECUTE : ST_FETCH;
          end
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_en  = 1'b1;
        state_d = (opcode == c_op_lw) ? ST_MEMREAD : ST_MEMWRITE;
      end
      ST_MEMREAD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        alu_en  = 1'b1;
        if (overflow && (funct == c_fn_add || funct == c_fn_sub)) ovf_flag_d = 1'b1;
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = ~ovf_flag_q;
        exception = ovf_flag_q;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        alu_op      = ALUOP_SUB;
        alu_en      = 1'b1;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_en  = 1'b1;
        if (overflow) ovf_flag_d = 1'b1;
        state_d = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        RegWrite  = ~ovf_flag_q;
        exception = ovf_flag_q;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_RESET;
    endcase

    // States that do not use the ALU report operation 000.
    ALUControl = alu_en ? alu_ctrl_dec : 3'b000;
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control: randomized instruction streams against a step model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  typedef struct packed {
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       pc_write_cond;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal;
    logic       exception;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        overflow;
  logic [1:0]  PCSource, ALUSrcB;
  logic        ALUSrcA, RegWrite, RegDst, PCWriteCond, PCWrite, IorD;
  logic        MemRead, MemWrite, MemToReg, IRWrite, illegal, exception;
  logic [2:0]  ALUControl;
  logic [3:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_states[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .overflow    (overflow),
    .PCSource    (PCSource),
    .ALUSrcB     (ALUSrcB),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .PCWriteCond (PCWriteCond),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemToReg    (MemToReg),
    .IRWrite     (IRWrite),
    .ALUControl  (ALUControl),
    .state       (state),
    .illegal     (illegal),
    .exception   (exception)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t observed();
    ctrl_t o;
    o = '{PCSource, ALUSrcB, ALUSrcA, RegWrite, RegDst, PCWriteCond, PCWrite, IorD,
          MemRead, MemWrite, MemToReg, IRWrite, ALUControl, state, illegal, exception};
    return o;
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit instr_legal(input logic [31:0] ins);
    if (ins[31:26] == 6'b000000) return funct_ok(ins[5:0]);
    return ins[31:26] inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Step sequence an instruction walks through, as state numbers.
  task automatic build_steps(input logic [31:0] ins);
    exp_states = '{1, 2};
    if (instr_legal(ins)) begin
      case (ins[31:26])
        6'b100011: exp_states = {exp_states, 3, 4, 5};
        6'b101011: exp_states = {exp_states, 3, 6};
        6'b000000: exp_states = {exp_states, 7, 8};
        6'b000100: exp_states = {exp_states, 9};
        6'b001000: exp_states = {exp_states, 10, 11};
        default:   exp_states = {exp_states, 12};
      endcase
    end
  endtask

  function automatic ctrl_t exp_ctrl(input int st, input logic [31:0] ins, input bit flag);
    ctrl_t e;
    e       = '0;
    e.state = st[3:0];
    case (st)
      1: begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010; end
      2: begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.illegal = !instr_legal(ins); end
      3: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      4: begin e.iord = 1; e.mem_read = 1; end
      5: begin e.reg_write = 1; e.mem_to_reg = 1; end
      6: begin e.iord = 1; e.mem_write = 1; end
      7: begin e.alu_src_a = 1; e.alu_control = funct_alu(ins[5:0]); end
      8: begin e.reg_dst = 1; e.reg_write = !flag; e.exception = flag; end
      9: begin e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_source = 2'b01; e.pc_write_cond = 1; end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
      11: begin e.reg_write = !flag; e.exception = flag; end
      12: begin e.pc_source = 2'b10; e.pc_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Entered and left at 1 time unit after a rising edge, with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input bit ovf, input string tag);
    bit flag;
    int st;
    flag = ovf && ((ins[31:26] == 6'b000000 && ins[5:0] inside {6'b100000, 6'b100010})
                   || ins[31:26] == 6'b001000);
    build_steps(ins);
    for (int i = 0; i < exp_states.size(); i++) begin
      st = exp_states[i];
      check_eq($sformatf("%s ins=%h step%0d st%0d", tag, ins, i, st),
               32'(observed()), 32'(exp_ctrl(st, ins, flag)));
      if (i == 0) instruction = ins;
      overflow = (st == 7 || st == 10) ? ovf : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  valid_fn [5];
    int          k;
    valid_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ins = $urandom;
    k   = $urandom_range(0, 11);
    case (k)
      0: ins[31:26] = 6'b100011;
      1: ins[31:26] = 6'b101011;
      2: ins[31:26] = 6'b000100;
      3: ins[31:26] = 6'b001000;
      4: ins[31:26] = 6'b000010;
      10: begin
        ins[31:26] = 6'b000000;
        while (funct_ok(ins[5:0])) ins[5:0] = 6'($urandom);
      end
      11: begin
        while (ins[31:26] inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})
          ins[31:26] = 6'($urandom);
      end
      default: begin
        ins[31:26] = 6'b000000;
        ins[5:0]   = valid_fn[k-5];
      end
    endcase
    return ins;
  endfunction

  initial begin
    rst         = 1'b0;
    overflow    = 1'b0;
    instruction = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hold", 32'(observed()), 32'(exp_ctrl(0, 32'h0, 0)));
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    run_instr(32'h8C220004, 0, "lw");
    run_instr(32'h00221820, 0, "add");
    run_instr(32'h00221820, 1, "add_ovf");
    run_instr(32'h00221824, 0, "and_after_ovf");
    run_instr(32'h0022182A, 1, "slt_ovf");
    run_instr(32'h20220005, 1, "addi_ovf");
    run_instr(32'h10220003, 0, "beq");
    run_instr(32'h08000010, 0, "j");
    run_instr(32'hAC220008, 0, "sw");
    run_instr(32'hFC000000, 0, "ill_op");
    run_instr(32'h00221807, 0, "ill_fn");

    for (int n = 0; n < 300; n++) run_instr(rand_instr(), 1'($urandom_range(0, 1)), "rand");

    // Asynchronous reset landing in the middle of an add.
    instruction = 32'h00221820;
    overflow    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_exec_state", 32'(observed()), 32'(exp_ctrl(7, 32'h00221820, 0)));
    overflow = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_async", 32'(observed()), 32'(exp_ctrl(0, 32'h0, 0)));
    @(posedge clk);
    #1;
    check_eq("rst_held", 32'(observed()), 32'(exp_ctrl(0, 32'h0, 0)));
    #3 rst = 1'b1;
    overflow = 1'b0;
    @(posedge clk);
    #1;
    run_instr(32'h00221820, 0, "add_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
